// File: rtl/rect_raster.sv
// Rectangle rasteriser: scans a latched rectangle row-major and streams the
// on-screen (and, in outline mode, border-only) pixels over a valid/ready port.
module rect_raster #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int SZ_W  = 5,
    parameter int C_W   = 3,
    parameter int SCR_W = 160,
    parameter int SCR_H = 120
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [X_W-1:0]  req_x,
    input  logic [Y_W-1:0]  req_y,
    input  logic [SZ_W-1:0] req_w,
    input  logic [SZ_W-1:0] req_h,
    input  logic [C_W-1:0]  req_c,
    input  logic            req_mode,
    input  logic            abort,
    output logic            pix_valid,
    output logic [X_W-1:0]  pix_x,
    output logic [Y_W-1:0]  pix_y,
    output logic [C_W-1:0]  pix_c,
    input  logic            pix_ready,
    output logic            busy,
    output logic            done
);

    localparam int XP_W = X_W + 1;
    localparam int YP_W = Y_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [X_W-1:0]  x_r;
    logic [Y_W-1:0]  y_r;
    logic [SZ_W-1:0] w_r;
    logic [SZ_W-1:0] h_r;
    logic [C_W-1:0]  c_r;
    logic            mode_r;
    logic [SZ_W-1:0] cx_r;
    logic [SZ_W-1:0] cy_r;
    logic            vld_r;
    logic [X_W-1:0]  pix_x_r;
    logic [Y_W-1:0]  pix_y_r;

    logic            col_end_s;
    logic            last_s;
    logic            advance_s;
    logic [SZ_W-1:0] ncx_s;
    logic [SZ_W-1:0] ncy_s;
    logic [XP_W-1:0] nx_s;
    logic [YP_W-1:0] ny_s;
    logic            nok_s;
    logic            acc_ok_s;

    // Coordinates are widened by one bit so a rectangle crossing the right or
    // bottom edge is clipped instead of wrapping back to column/row 0.
    function automatic logic cand_ok(
        input logic [X_W-1:0]  x,
        input logic [Y_W-1:0]  y,
        input logic [SZ_W-1:0] w,
        input logic [SZ_W-1:0] h,
        input logic [SZ_W-1:0] cx,
        input logic [SZ_W-1:0] cy,
        input logic            mode
    );
        logic [XP_W-1:0] px;
        logic [YP_W-1:0] py;
        logic            on_scr;
        logic            border;
        px     = {1'b0, x} + XP_W'(cx);
        py     = {1'b0, y} + YP_W'(cy);
        on_scr = (px < XP_W'(SCR_W)) && (py < YP_W'(SCR_H));
        border = !mode || (cx == {SZ_W{1'b0}}) || (cx == w - SZ_W'(1)) ||
                 (cy == {SZ_W{1'b0}}) || (cy == h - SZ_W'(1));
        return on_scr && border;
    endfunction

    // Next scan offset and whether that next candidate will be emitted.
    always_comb begin
        col_end_s = (cx_r == w_r - SZ_W'(1));
        last_s    = col_end_s && (cy_r == h_r - SZ_W'(1));
        advance_s = !vld_r || pix_ready;
        ncx_s     = col_end_s ? {SZ_W{1'b0}} : cx_r + SZ_W'(1);
        ncy_s     = col_end_s ? cy_r + SZ_W'(1) : cy_r;
        nx_s      = {1'b0, x_r} + XP_W'(ncx_s);
        ny_s      = {1'b0, y_r} + YP_W'(ncy_s);
        nok_s     = cand_ok(x_r, y_r, w_r, h_r, ncx_s, ncy_s, mode_r);
        acc_ok_s  = cand_ok(req_x, req_y, req_w, req_h, {SZ_W{1'b0}}, {SZ_W{1'b0}}, req_mode);
    end

    // Output decode; abort suppresses the pixel in the same cycle.
    always_comb begin
        req_ready = (state_r == IDLE);
        busy      = (state_r == DRAW);
        done      = (state_r == DONE);
        pix_valid = (state_r == DRAW) && vld_r && !abort;
        pix_x     = pix_x_r;
        pix_y     = pix_y_r;
        pix_c     = c_r;
    end

    // Control FSM, request latch and scan counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            x_r     <= {X_W{1'b0}};
            y_r     <= {Y_W{1'b0}};
            w_r     <= {SZ_W{1'b0}};
            h_r     <= {SZ_W{1'b0}};
            c_r     <= {C_W{1'b0}};
            mode_r  <= 1'b0;
            cx_r    <= {SZ_W{1'b0}};
            cy_r    <= {SZ_W{1'b0}};
            vld_r   <= 1'b0;
            pix_x_r <= {X_W{1'b0}};
            pix_y_r <= {Y_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        x_r    <= req_x;
                        y_r    <= req_y;
                        w_r    <= req_w;
                        h_r    <= req_h;
                        c_r    <= req_c;
                        mode_r <= req_mode;
                        cx_r   <= {SZ_W{1'b0}};
                        cy_r   <= {SZ_W{1'b0}};
                        if ((req_w == {SZ_W{1'b0}}) || (req_h == {SZ_W{1'b0}})) begin
                            state_r <= DONE;
                            vld_r   <= 1'b0;
                        end else begin
                            state_r <= DRAW;
                            vld_r   <= acc_ok_s;
                            if (acc_ok_s) begin
                                pix_x_r <= req_x;
                                pix_y_r <= req_y;
                            end
                        end
                    end
                end
                DRAW: begin
                    if (abort || (advance_s && last_s)) begin
                        state_r <= DONE;
                        vld_r   <= 1'b0;
                    end else if (advance_s) begin
                        cx_r  <= ncx_s;
                        cy_r  <= ncy_s;
                        vld_r <= nok_s;
                        if (nok_s) begin
                            pix_x_r <= nx_s[X_W-1:0];
                            pix_y_r <= ny_s[Y_W-1:0];
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    vld_r   <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    vld_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rect_raster.sv
// Self-checking bench for rect_raster: directed cases plus randomised requests
// compared against a nested-loop reference model of the pixel set.
module tb_rect_raster;

    localparam int X_W = 8, Y_W = 7, SZ_W = 5, C_W = 3, SCR_W = 160, SCR_H = 120;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [X_W-1:0]  req_x = '0;
    logic [Y_W-1:0]  req_y = '0;
    logic [SZ_W-1:0] req_w = '0;
    logic [SZ_W-1:0] req_h = '0;
    logic [C_W-1:0]  req_c = '0;
    logic            req_mode = 1'b0;
    logic            abort = 1'b0;
    logic            pix_valid;
    logic [X_W-1:0]  pix_x;
    logic [Y_W-1:0]  pix_y;
    logic [C_W-1:0]  pix_c;
    logic            pix_ready = 1'b0;
    logic            busy;
    logic            done;

    int total = 0;
    int bad   = 0;

    rect_raster #(.X_W(X_W), .Y_W(Y_W), .SZ_W(SZ_W), .C_W(C_W),
                  .SCR_W(SCR_W), .SCR_H(SCR_H)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
        .req_c(req_c), .req_mode(req_mode), .abort(abort),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_c(pix_c),
        .pix_ready(pix_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full request: model builds the expected pixel list, the loop drives
    // pix_ready and checks order, hold under backpressure and done timing.
    task automatic do_req(input int x, input int y, input int w, input int h,
                          input int c, input int mode, input int ready_pct,
                          input int stall_first);
        int ex[$];
        int ey[$];
        int stalls = 0, busy_n = 0, cyc = 0, hs = 0, first_stalls = 0;
        logic seen_done = 1'b0;
        logic prev_stall = 1'b0;
        logic [31:0] px_prev = 0, py_prev = 0;
        for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++)
                if (x + i < SCR_W && y + j < SCR_H &&
                    (mode == 0 || i == 0 || i == w - 1 || j == 0 || j == h - 1)) begin
                    ex.push_back(x + i);
                    ey.push_back(y + j);
                end
        chk("ready_before_req", req_ready, 1);
        req_valid = 1'b1;
        req_x = X_W'(x); req_y = Y_W'(y); req_w = SZ_W'(w); req_h = SZ_W'(h);
        req_c = C_W'(c); req_mode = mode[0];
        @(negedge clk);
        req_valid = 1'b0;
        while (cyc < 3000) begin
            cyc++;
            if (done === 1'b1) begin
                seen_done = 1'b1;
                break;
            end
            if (busy === 1'b1) busy_n++;
            if (prev_stall) begin
                chk("hold_valid", pix_valid, 1);
                chk("hold_x", pix_x, px_prev);
                chk("hold_y", pix_y, py_prev);
            end
            if (pix_valid === 1'b1) begin
                chk("pix_c", pix_c, c);
                if (hs == 0 && first_stalls < stall_first) begin
                    pix_ready = 1'b0;
                    first_stalls++;
                end else begin
                    pix_ready = ($urandom_range(99) < ready_pct);
                end
                if (pix_ready) begin
                    hs++;
                    if (ex.size() == 0) chk("extra_pixel", 1, 0);
                    else begin
                        chk("pix_x", pix_x, ex.pop_front());
                        chk("pix_y", pix_y, ey.pop_front());
                    end
                end else begin
                    stalls++;
                end
                prev_stall = !pix_ready;
                px_prev = pix_x;
                py_prev = pix_y;
            end else begin
                pix_ready = $urandom_range(1) == 1;
                prev_stall = 1'b0;
            end
            @(negedge clk);
        end
        chk("done_seen", seen_done, 1);
        chk("done_cycle", cyc, w * h + stalls + 1);
        chk("busy_cycles", busy_n, w * h + stalls);
        chk("missing_pixels", ex.size(), 0);
        chk("done_no_pix", pix_valid, 0);
        pix_ready = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("ready_after", req_ready, 1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_valid", pix_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_x", pix_x, 0);
        chk("rst_y", pix_y, 0);
        chk("rst_c", pix_c, 0);
        reset = 1'b1;
        @(negedge clk);

        // Directed shapes
        do_req(10, 20, 3, 2, 5, 0, 100, 0);
        do_req(0, 0, 4, 4, 3, 1, 100, 0);
        do_req(158, 118, 4, 3, 6, 0, 100, 0);
        do_req(40, 50, 2, 1, 2, 0, 100, 3);
        do_req(7, 9, 0, 5, 1, 0, 100, 0);
        do_req(30, 30, 1, 5, 4, 1, 100, 0);
        do_req(200, 10, 3, 3, 1, 0, 100, 0);

        // Abort after the second handshake of a 5x5 fill
        pix_ready = 1'b1;
        req_valid = 1'b1;
        req_x = 8'd20; req_y = 7'd30; req_w = 5'd5; req_h = 5'd5;
        req_c = 3'd7; req_mode = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_p1_valid", pix_valid, 1);
        @(negedge clk);
        chk("abort_p2_x", pix_x, 21);
        @(negedge clk);
        abort = 1'b1;
        #1;
        chk("abort_valid_low", pix_valid, 0);
        chk("abort_busy", busy, 1);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_done", done, 1);
        chk("abort_no_pix", pix_valid, 0);
        @(negedge clk);
        chk("abort_idle", req_ready, 1);
        chk("abort_done_clr", done, 0);

        // Reset mid-DRAW, with abort and req_valid also asserted
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        abort = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        abort = 1'b0;
        req_valid = 1'b0;
        chk("mrst_done", done, 0);
        chk("mrst_ready", req_ready, 1);
        chk("mrst_busy", busy, 0);
        chk("mrst_valid", pix_valid, 0);
        chk("mrst_x", pix_x, 0);
        @(negedge clk);
        chk("mrst_no_done", done, 0);
        chk("mrst_ready2", req_ready, 1);
        pix_ready = 1'b0;

        // Randomised requests
        for (int k = 0; k < 25; k++) begin
            int rx, ry, rw, rh;
            rx = (k % 3 == 0) ? int'($urandom_range(150, 159)) : int'($urandom_range(255));
            ry = (k % 4 == 0) ? int'($urandom_range(112, 127)) : int'($urandom_range(127));
            rw = $urandom_range(12);
            rh = $urandom_range(12);
            do_req(rx, ry, rw, rh, $urandom_range(7), $urandom_range(1),
                   $urandom_range(30, 100), $urandom_range(2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
